// File: rtl/pc_fetch_if.sv
// pc_fetch_if: control inputs and fetch-address outputs of the PC fetch stage.
interface pc_fetch_if;
  logic        stall;
  logic        imem_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic [31:0] fetch_count;
  logic        misalign_err;
  modport master (
    input  stall, imem_ready, redirect, redirect_target, halt,
    output pc, pc_plus4, fetch_valid, fetch_count, misalign_err
  );
  modport slave (
    output stall, imem_ready, redirect, redirect_target, halt,
    input  pc, pc_plus4, fetch_valid, fetch_count, misalign_err
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program counter with fetch handshake, pending redirect and halt.
// Define PC_ALIGN_CHECK_EN to halt on misaligned redirect targets instead of masking them.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        reset_n,
  pc_fetch_if.master bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t      state, state_nx;
  logic [31:0] pc_q, cnt_q, pend_q, tgt, pc_nx;
  logic        pend_v, hs, take, bad;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.fetch_valid = state == RUN;
  assign bus.fetch_count = cnt_q;
  always_comb begin
    hs       = (state == RUN) & bus.imem_ready & ~bus.stall & ~bus.halt;
    take     = bus.redirect | pend_v;
    tgt      = bus.redirect ? bus.redirect_target : pend_q;
`ifdef PC_ALIGN_CHECK_EN
    bad      = hs & take & (|tgt[1:0]);
    pc_nx    = take ? tgt : bus.pc_plus4;
`else
    bad      = 1'b0;
    pc_nx    = take ? (tgt & ~32'd3) : bus.pc_plus4;
`endif
    state_nx = state == BOOT ? RUN :
               (state == RUN && (bus.halt || bad)) ? HALT : state;
  end
  // A misaligned target aborts the fetch: neither pc nor fetch_count moves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= BOOT;
      pc_q   <= RESET_PC;
      cnt_q  <= '0;
      pend_q <= '0;
      pend_v <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs && !bad) begin
        pc_q  <= pc_nx;
        cnt_q <= cnt_q + 32'd1;
      end
      if (state == RUN) begin
        if (bus.halt || hs) pend_v <= 1'b0;
        else if (bus.redirect) begin
          pend_v <= 1'b1;
          pend_q <= bus.redirect_target;
        end
      end
    end
  end
`ifdef PC_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= bad;
  end
  assign bus.misalign_err = err_q;
`else
  assign bus.misalign_err = 1'b0;
`endif
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hazard hold; 1 blocks PC advance.
REQ-005 imem_ready  input  1  instruction memory accepts current fetch.
REQ-006 redirect  input  1  take redirect_target instead of sequential PC.
REQ-007 redirect_target  input  32  branch/jump target from target adder.
REQ-008 halt  input  1  stop fetching until reset.
REQ-009 pc  output  32  current fetch address.
REQ-010 pc_plus4  output  32  pc + 4, modulo 2^32, combinational from pc.
REQ-011 fetch_valid  output  1  pc is a valid fetch request.
REQ-012 fetch_count  output  32  number of completed fetch handshakes.
REQ-013 misalign_err  output  1  misaligned redirect detected (REQ-031).

Function
REQ-014 States: BOOT, RUN, HALT; encoding free, not exported.
REQ-015 BOOT: fetch_valid=0; next cycle unconditionally RUN.
REQ-016 RUN: fetch_valid=1.
REQ-017 Handshake = fetch_valid & imem_ready & ~stall; PC advances only on handshake.
REQ-018 Handshake next PC priority: live redirect > pending redirect > pc_plus4.
REQ-019 Redirect with no handshake that cycle: target captured in pending register (pend_valid=1); later redirect overwrites it.
REQ-020 Pending register cleared on the handshake that consumes it or on a live redirect handshake.
REQ-021 No handshake: pc, fetch_count, pending contents unchanged except per REQ-019.
REQ-022 fetch_count increments by 1 per handshake, wraps 32'hFFFF_FFFF -> 0.
REQ-023 pc_plus4 wraps: pc=32'hFFFF_FFFC -> pc_plus4=0; sequential fetch follows the wrap.
REQ-024 halt=1 in RUN: no handshake that cycle, next state HALT; halt wins over simultaneous imem_ready/redirect; pending discarded.
REQ-025 HALT: fetch_valid=0, pc/fetch_count frozen, all inputs ignored; exit only via reset.
REQ-026 Redirect/halt/stall in BOOT ignored (redirect not captured).
REQ-027 Latency: handshake at edge N -> new pc visible after edge N; one fetch per cycle maximum.

Reset
REQ-028 reset_n=0 asynchronously: state=BOOT, pc=RESET_PC, fetch_count=0, pend_valid=0, misalign_err=0, fetch_valid=0.
REQ-029 Reset mid-operation (any state, any stall/pending) yields exactly REQ-028 values; no in-flight redirect survives.
REQ-030 Release synchronous to clk assumed by integration; first fetch_valid=1 one cycle after release.

Configuration
REQ-031 Macro PC_ALIGN_CHECK_EN defined: redirect target with bits[1:0]!=00 (live or on consumption) not taken; misalign_err=1 for one cycle, next state HALT, pc holds.
REQ-032 Macro PC_ALIGN_CHECK_EN undefined: target bits[1:0] forced to 00 on load; misalign_err tied 0.

Verification
REQ-033 Reset, imem_ready=1, no stall, 4 cycles -> pc 0,4,8,C; fetch_count=4; fetch_valid low only in BOOT.
REQ-034 pc=8, redirect=1, target=0x100, imem_ready=0 one cycle then 1 -> pc stays 8, then 0x100; pending cleared.
REQ-035 stall=1 three cycles at pc=0x20 -> pc=0x20, fetch_count unchanged; after release pc=0x24.
REQ-036 pc=0xFFFF_FFFC, handshake -> pc=0, pc_plus4=4; fetch_count from 0xFFFF_FFFF -> 0.
REQ-037 halt with simultaneous redirect at pc=0x40 -> pc stays 0x40, fetch_valid=0 forever; reset_n low mid-HALT -> pc=RESET_PC, BOOT.
REQ-038 redirect target 0x102: with PC_ALIGN_CHECK_EN -> misalign_err one pulse, HALT, pc unchanged; without -> pc=0x100, misalign_err=0.
